// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch queue: a 4-entry FIFO of {PC, instruction} pairs fed from a combinational-read IMEM.
// Optional PREFETCH_STATS_EN adds saturating pop (FetchCount) and redirect (FlushCount) counters.
module if_prefetch (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        InstrReady,
    output logic        InstrValid,
    output logic [31:0] InstrOut,
    output logic [31:0] PCOut,
    output logic [31:0] PCPlus4,
`ifdef PREFETCH_STATS_EN
    output logic [31:0] FetchCount,
    output logic [15:0] FlushCount,
`endif
    output logic [2:0]  QueueCount
);

    logic [31:0] pc_q   [4];
    logic [31:0] instr_q[4];
    logic [1:0]  head;
    logic [1:0]  tail;
    logic [2:0]  count;
    logic [31:0] fetch_pc;
    logic        pop;
    logic        push;

    assign pop  = (count != 3'd0) & InstrReady & ~Redirect;
    assign push = ~Redirect & ((count < 3'd4) | pop);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            head     <= 2'd0;
            tail     <= 2'd0;
            count    <= 3'd0;
            fetch_pc <= 32'h0;
        end else if (Redirect) begin
            head     <= 2'd0;
            tail     <= 2'd0;
            count    <= 3'd0;
            fetch_pc <= {RedirectPC[31:2], 2'b00};
        end else begin
            if (push) begin
                tail     <= tail + 2'd1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop)
                head <= head + 2'd1;
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop)
                count <= count + 3'd1;
            else if (pop && !push)
                count <= count - 3'd1;
        end
    end

    // Storage needs no reset; occupancy gates everything visible.
    always_ff @(posedge Clk) begin
        if (!Reset && push) begin
            pc_q[tail]    <= fetch_pc;
            instr_q[tail] <= IMemData;
        end
    end

    assign IMemAddr   = fetch_pc;
    assign QueueCount = count;
    assign InstrValid = (count != 3'd0);
    assign InstrOut   = InstrValid ? instr_q[head] : 32'h0;
    assign PCOut      = InstrValid ? pc_q[head] : 32'h0;
    assign PCPlus4    = InstrValid ? pc_q[head] + 32'd4 : 32'h0;

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FetchCount <= 32'h0;
            FlushCount <= 16'h0;
        end else begin
            if (pop && FetchCount != 32'hFFFF_FFFF)
                FetchCount <= FetchCount + 32'd1;
            if (Redirect && FlushCount != 16'hFFFF)
                FlushCount <= FlushCount + 16'd1;
        end
    end
`endif

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: Clk and Reset.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high; sampled on rising Clk.
REQ-004 IMemAddr  output  32  fetch address to instruction memory; combinational read, data valid same cycle.
REQ-005 IMemData  input  32  instruction word at IMemAddr.
REQ-006 Redirect  input  1  branch/jump taken; flush and refetch.
REQ-007 RedirectPC  input  32  target address used when Redirect=1.
REQ-008 InstrReady  input  1  decode stage accepts head entry this cycle.
REQ-009 InstrValid  output  1  head entry present.
REQ-010 InstrOut  output  32  head instruction word.
REQ-011 PCOut  output  32  address of head instruction.
REQ-012 PCPlus4  output  32  PCOut+4, modulo 2^32.
REQ-013 QueueCount  output  3  entries held, range 0..4.

Function
REQ-014 The block SHALL hold a 4-entry FIFO of {PC, instruction} pairs, with 2-bit head and tail pointers that wrap 3->0.
REQ-015 FetchPC register SHALL drive IMemAddr directly, with no combinational path from any input.
REQ-016 pop = InstrValid & InstrReady & ~Redirect; InstrReady while InstrValid=0 SHALL have no effect.
REQ-017 push = ~Redirect & (QueueCount<4 | pop); on push, {FetchPC, IMemData} SHALL be written at tail, tail SHALL advance, and FetchPC SHALL become FetchPC+4.
REQ-018 When full and popped in the same cycle, the block SHALL push and pop together and QueueCount SHALL remain 4.
REQ-019 When empty and pushed, the entry SHALL appear at the outputs on the next cycle; fetch-to-output latency is 1 cycle.
REQ-020 Redirect SHALL have priority over everything: QueueCount<=0, head<=tail<=0, FetchPC<=RedirectPC with bits[1:0] forced to 0, no push, head discarded.
REQ-021 FetchPC SHALL wrap 0xFFFFFFFC -> 0x00000000; PCPlus4 SHALL wrap likewise.
REQ-022 When InstrValid=0, InstrOut, PCOut and PCPlus4 SHALL be driven to 0.
REQ-023 InstrValid SHALL equal (QueueCount!=0), driven from registered state only.
REQ-024 Head outputs SHALL remain stable while InstrValid=1 and InstrReady=0.

Reset
REQ-025 Reset SHALL take priority over Redirect and over every push and pop.
REQ-026 Reset SHALL set FetchPC=0x00000000, pointers=0, QueueCount=0, InstrValid=0, InstrOut=PCOut=PCPlus4=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries within that cycle.
REQ-028 The first push SHALL occur on the first rising edge with Reset=0; InstrValid SHALL rise after that edge, with PCOut=0.

Configuration
REQ-029 Macro PREFETCH_STATS_EN: when defined, the block SHALL add output FetchCount (32 bits) and output FlushCount (16 bits).
REQ-030 With PREFETCH_STATS_EN defined, FetchCount SHALL increment on each pop and FlushCount SHALL increment on each Redirect; both SHALL be zeroed by Reset and saturate at their maximum value.
REQ-031 With PREFETCH_STATS_EN undefined, the block SHALL have neither port nor any counter logic, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset released, InstrReady=0, memory word at address n = n -> after 4 cycles QueueCount=4, IMemAddr=0x10, PCOut=0x0, InstrOut=0x0; state then holds.
REQ-033 From full, InstrReady=1 continuously -> one pop per cycle, PCOut steps 0x0,0x4,0x8,...; QueueCount stays 4; FIFO entries appear in order across the pointer wrap.
REQ-034 Redirect=1 with RedirectPC=0x00000123 while QueueCount=3 -> next cycle QueueCount=0, InstrValid=0, IMemAddr=0x120; following cycle PCOut=0x120.
REQ-035 Redirect=1 with RedirectPC=0xFFFFFFFC, then InstrReady=1 -> PCOut=0xFFFFFFFC with PCPlus4=0x0, then PCOut=0x0.
REQ-036 Reset pulsed for 1 cycle while QueueCount=2 and InstrReady=1 -> next cycle all outputs 0 and FetchPC=0; if PREFETCH_STATS_EN is defined, FetchCount=0.
REQ-037 With PREFETCH_STATS_EN defined: 10 pops followed by 2 Redirects -> FetchCount=10, FlushCount=2.
